// File: rtl/exe_stage_ctrl_pkg.sv
// Shared EXE-stage constants: default multi-cycle occupancy and the width of the
// occupancy counter derived from it, so the neighbouring stage controllers agree.
package exe_stage_ctrl_pkg;

    // One extra bit beyond clog2 keeps MDU_CYCLES-1 representable for every legal value.
    function automatic int cnt_width(input int cycles);
        return $clog2(cycles) + 1;
    endfunction

    localparam int MDU_CYCLES_DEF = 4;
    localparam int CNT_W_DEF      = cnt_width(MDU_CYCLES_DEF);

endpackage

// File: rtl/exe_stage_ctrl_mdu_busy_counter.sv
// Load/decrement/clear counter tracking the remaining EXE stall cycles of a
// multi-cycle instruction; zero marks the result as complete.
module exe_stage_ctrl_mdu_busy_counter
    import exe_stage_ctrl_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic [CNT_W-1:0] cnt,
    output logic             zero
);

    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_q;

    always_comb begin
        // NOTE: default assignment first so every path drives cnt_d and no latch is inferred.
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt  = cnt_q;
    assign zero = (cnt_q == '0);

endmodule

// File: rtl/exe_stage_ctrl.sv
// EXE-stage valid/allowin controller: loads the EXE register, stalls for mul/div,
// presents exe_to_mem_valid and derives the forwarding / load-use flags for ID.
module exe_stage_ctrl
    import exe_stage_ctrl_pkg::*;
#(
    parameter int MDU_CYCLES = MDU_CYCLES_DEF,
    parameter int CNT_W      = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_to_exe_valid,
    input  logic             exe_multi_in,
    input  logic             mem_allowin,
    input  logic             flush,
    input  logic             exe_rf_we,
    input  logic             exe_lw_instr,
    output logic             exe_allowin,
    output logic             exe_valid,
    output logic             exe_ready_go,
    output logic             exe_to_mem_valid,
    output logic [CNT_W-1:0] exe_busy_cnt,
    output logic             exe_fwd_valid,
    output logic             exe_load_hazard
);

    localparam logic [CNT_W-1:0] MDU_LOAD = CNT_W'(MDU_CYCLES - 1);

    logic             exe_valid_d;
    logic             exe_valid_q;
    logic             accept;
    logic [CNT_W-1:0] busy_load_val;

    assign exe_allowin      = !exe_valid_q || (exe_ready_go && mem_allowin);
    assign accept           = exe_allowin && id_to_exe_valid;
    assign exe_to_mem_valid = exe_valid_q && exe_ready_go;
    assign exe_fwd_valid    = exe_valid_q && exe_ready_go && exe_rf_we && !exe_lw_instr;
    assign exe_load_hazard  = exe_valid_q && exe_rf_we && exe_lw_instr;
    assign exe_valid        = exe_valid_q;

    // A single-cycle accept (or MDU_CYCLES==1) reloads zero, so the counter never leaves 0.
    assign busy_load_val = exe_multi_in ? MDU_LOAD : '0;

    always_comb begin
        exe_valid_d = exe_valid_q;
        if (flush) begin
            exe_valid_d = 1'b0;
        end else if (exe_allowin) begin
            exe_valid_d = id_to_exe_valid;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exe_valid_q <= 1'b0;
        end else begin
            exe_valid_q <= exe_valid_d;
        end
    end

    // A bubble accept needs no explicit clear: the counter only runs while live,
    // and both flush and any accept leave it at zero unless a mul/div is loaded.
    exe_stage_ctrl_mdu_busy_counter #(
        .CNT_W (CNT_W)
    ) u_busy_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (flush),
        .load     (accept),
        .load_val (busy_load_val),
        .cnt      (exe_busy_cnt),
        .zero     (exe_ready_go)
    );

endmodule

// File: doc/exe_stage_ctrl.md
Name: exe_stage_ctrl

Overview:
Valid/allowin handshake controller for the EXE stage. It generates the exe_allowin strobe that loads the EXE pipeline register, and it tracks whether that register holds a live instruction. It stalls for multi-cycle MUL/DIV operations and presents exe_to_mem_valid downstream. It also derives the EXE-stage forwarding-valid and load-use hazard flags that the ID stage consumes.

Parameters:
MDU_CYCLES, 4, total EXE occupancy of a multi-cycle (mul/div) instruction in cycles; legal range >=1.
CNT_W, 3, width of the occupancy counter; must hold MDU_CYCLES-1.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
id_to_exe_valid  in  1  ID stage presents a valid instruction
exe_multi_in  in  1  incoming instruction is multi-cycle (mul/div); sampled with id_to_exe_valid
mem_allowin  in  1  MEM stage can accept this cycle
flush  in  1  kill the EXE-stage instruction (branch/exception redirect)
exe_rf_we  in  1  rf_we of the instruction held in the EXE register
exe_lw_instr  in  1  lw flag of the instruction held in the EXE register
exe_allowin  out  1  load enable for the EXE pipeline register; combinational
exe_valid  out  1  EXE register holds a live instruction; registered
exe_ready_go  out  1  EXE result complete this cycle; combinational
exe_to_mem_valid  out  1  exe_valid && exe_ready_go
exe_busy_cnt  out  CNT_W  remaining stall cycles; registered
exe_fwd_valid  out  1  EXE result may be bypassed to ID
exe_load_hazard  out  1  ID must stall; lw result is not yet available

Behaviour:
- Reset (async, rst_n=0): exe_valid=0, exe_busy_cnt=0. Consequently exe_allowin=1, exe_ready_go=1, exe_to_mem_valid=0, exe_fwd_valid=0, exe_load_hazard=0.
- exe_ready_go = (exe_busy_cnt == 0).
- exe_allowin = !exe_valid || (exe_ready_go && mem_allowin).
- exe_to_mem_valid = exe_valid && exe_ready_go.
- exe_fwd_valid = exe_valid && exe_ready_go && exe_rf_we && !exe_lw_instr.
- exe_load_hazard = exe_valid && exe_rf_we && exe_lw_instr.
- accept = exe_allowin && id_to_exe_valid.
- exe_valid update, in priority order:
  - flush -> 0
  - else if exe_allowin -> id_to_exe_valid
  - else hold
- exe_busy_cnt update, in priority order:
  - flush -> 0
  - else if accept && exe_multi_in -> MDU_CYCLES-1
  - else if accept -> 0
  - else if cnt != 0 -> cnt-1
  - else hold 0
- Latency: a single-cycle instruction reaches exe_to_mem_valid in the cycle after acceptance. A multi-cycle instruction asserts it MDU_CYCLES cycles after acceptance.
- MDU_CYCLES=1: a multi-cycle instruction behaves as single-cycle; the counter never leaves 0.
- mem_allowin low with ready_go=1: exe_valid holds, exe_allowin=0, and the counter stays at 0.
- The counter decrements regardless of mem_allowin. Back-pressure only lengthens the hold after completion.
- flush together with accept: flush wins. exe_valid=0 and cnt=0 next cycle. The register may still load (exe_allowin=1), but its contents are dead.
- Reset asserted mid-stall: the counter clears immediately and the stage is empty.
- Bubble accept (exe_allowin=1, id_to_exe_valid=0): exe_valid goes to 0 and the counter goes to 0.

Decomposition:
- Shared package: MDU_CYCLES default and the CNT_W derivation (clog2) as constants, so the ID/MEM stage controllers share them.
- One natural sub-module: mdu_busy_counter, a load/decrement/clear counter exposing zero.
- All remaining logic is inline combinational.

Test Plan:
- Reset then idle: rst_n low, then high; id_to_exe_valid=0 -> exe_allowin=1, exe_valid=0, exe_to_mem_valid=0.
- Single-cycle flow: id_to_exe_valid=1, exe_multi_in=0, mem_allowin=1 every cycle -> exe_valid=1 from cycle+1, exe_to_mem_valid=1 every cycle, exe_allowin stays 1.
- Multi-cycle stall (MDU_CYCLES=4): accept a multi-cycle op at T0 -> exe_busy_cnt is 3,2,1,0 at T1..T4; exe_allowin=0 at T1..T3; exe_to_mem_valid=1 at T4.
- MEM back-pressure: single-cycle op accepted, mem_allowin=0 for 3 cycles -> exe_valid held at 1, exe_allowin=0 for 3 cycles, then 1 on release.
- Flush mid-stall: flush at T2 of a 4-cycle op -> exe_valid=0 and cnt=0 at T3, exe_allowin=1 at T3.
- Hazard flags: exe_valid=1, exe_rf_we=1, exe_lw_instr=1 -> exe_load_hazard=1, exe_fwd_valid=0. With exe_lw_instr=0 -> exe_fwd_valid=1, exe_load_hazard=0.
